// File: rtl/ram2p_param_init.sv
// Parametrised 1R/1W synchronous RAM with per-lane write masks, write-first
// collision forwarding, optional output register and a hardware clear sequencer.
module ram2p_param_init #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int WIDTH   = 36,
  parameter int LANE_W  = 9,
  parameter int OUT_REG = 1
) (
  input  logic                       clockCore,
  input  logic                       resetCoreN,
  input  logic                       enableRead,
  input  logic [ADDR_W-1:0]          addressRead,
  input  logic                       enableWrite,
  input  logic [ADDR_W-1:0]          addressWrite,
  input  logic [WIDTH-1:0]           writeData,
  input  logic [WIDTH/LANE_W-1:0]    writeMask,
  input  logic                       startClear,
  output logic [WIDTH-1:0]           readData,
  output logic                       readValid,
  output logic                       initBusy
);

  localparam int unsigned LANES = WIDTH / LANE_W;
  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]    w_cnt_nxt;

  logic [WIDTH-1:0]     r_mem [DEPTH];

  logic                 w_run;
  logic                 w_wr_inrange;
  logic                 w_rd_inrange;
  logic                 w_rd_accept;
  logic                 w_fwd;
  logic [WIDTH-1:0]     w_rd_word;

  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_addr;
  logic [WIDTH-1:0]     w_mem_data;
  logic [LANES-1:0]     w_mem_lanes;

  logic                 r_rd_v1;
  logic [WIDTH-1:0]     r_rd_d1;

  assign w_run        = (r_state == RUN);
  assign w_wr_inrange = (int'(addressWrite) < DEPTH);
  assign w_rd_inrange = (int'(addressRead) < DEPTH);
  assign w_rd_accept  = w_run && enableRead;
  assign w_fwd        = enableWrite && w_wr_inrange && (addressWrite == addressRead);
  assign initBusy     = (r_state == CLEAR);

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLEAR: begin
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (startClear) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Single physical write port, shared by the clear sequencer and user writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = addressWrite[IDX_W-1:0];
    w_mem_data  = writeData;
    w_mem_lanes = writeMask;
    if (!w_run) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_cnt[IDX_W-1:0];
      w_mem_data  = '0;
      w_mem_lanes = '1;
    end else if (enableWrite && w_wr_inrange && (|writeMask)) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clockCore) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w_mem_lanes[i]) begin
          r_mem[w_mem_addr][i*LANE_W +: LANE_W] <= w_mem_data[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Write-first per lane: masked lanes of a same-address write bypass the array.
  always_comb begin
    w_rd_word = '0;
    if (w_rd_inrange) begin
      w_rd_word = r_mem[addressRead[IDX_W-1:0]];
      if (w_fwd) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (writeMask[i]) begin
            w_rd_word[i*LANE_W +: LANE_W] = writeData[i*LANE_W +: LANE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clockCore or negedge resetCoreN) begin
    if (!resetCoreN) begin
      r_rd_v1 <= 1'b0;
      r_rd_d1 <= '0;
    end else begin
      r_rd_v1 <= w_rd_accept;
      if (w_rd_accept) begin
        r_rd_d1 <= w_rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic             r_rd_v2;
    logic [WIDTH-1:0] r_rd_d2;

    always_ff @(posedge clockCore or negedge resetCoreN) begin
      if (!resetCoreN) begin
        r_rd_v2 <= 1'b0;
        r_rd_d2 <= '0;
      end else begin
        r_rd_v2 <= r_rd_v1;
        if (r_rd_v1) begin
          r_rd_d2 <= r_rd_d1;
        end
      end
    end

    assign readValid = r_rd_v2;
    assign readData  = r_rd_d2;
  end else begin : g_noreg
    assign readValid = r_rd_v1;
    assign readData  = r_rd_d1;
  end

endmodule

// File: tb/tb_ram2p_param_init.sv
// Bench for ram2p_param_init: two instances (256 words/latency 2 and
// 200 words/latency 1) share stimulus and are checked against an array model.
module tb_ram2p_param_init;

  logic        clk;
  logic        rst_n;
  logic        ren;
  logic [7:0]  raddr;
  logic        wen;
  logic [7:0]  waddr;
  logic [35:0] wdata;
  logic [3:0]  wmask;
  logic        sclr;

  logic [35:0] rd0, rd1;
  logic        v0, v1, b0, b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ram2p_param_init #(.DEPTH(256), .ADDR_W(8), .WIDTH(36), .LANE_W(9), .OUT_REG(1)) dut0 (
    .clockCore(clk), .resetCoreN(rst_n),
    .enableRead(ren), .addressRead(raddr),
    .enableWrite(wen), .addressWrite(waddr), .writeData(wdata), .writeMask(wmask),
    .startClear(sclr),
    .readData(rd0), .readValid(v0), .initBusy(b0)
  );

  ram2p_param_init #(.DEPTH(200), .ADDR_W(8), .WIDTH(36), .LANE_W(9), .OUT_REG(0)) dut1 (
    .clockCore(clk), .resetCoreN(rst_n),
    .enableRead(ren), .addressRead(raddr),
    .enableWrite(wen), .addressWrite(waddr), .writeData(wdata), .writeMask(wmask),
    .startClear(sclr),
    .readData(rd1), .readValid(v1), .initBusy(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one word array per instance, a count of clear cycles
  // still owed, and a queue of expected read results tagged with due cycle.
  typedef struct { int due; logic [35:0] d; } rd_t;

  logic [35:0] mm [2][256];
  int          clr [2];
  logic [35:0] last [2];
  rd_t         q0[$];
  rd_t         q1[$];
  int          DEP [2] = '{256, 200};
  int          LAT [2] = '{2, 1};

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      clr[k]  = DEP[k];
      last[k] = '0;
    end
  endtask

  task automatic step(input bit r, input logic [7:0] ra, input bit w, input logic [7:0] wa,
                      input logic [35:0] wd, input logic [3:0] wm, input bit sc);
    ren = r; raddr = ra; wen = w; waddr = wa; wdata = wd; wmask = wm; sclr = sc;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic [35:0] word;
      rd_t         item;
      if (!rst_n) continue;
      if (clr[k] > 0) begin
        clr[k]--;
        continue;
      end
      if (r) begin
        word = '0;
        if (int'(ra) < DEP[k]) begin
          word = mm[k][ra];
          for (int l = 0; l < 4; l++)
            if (w && wa == ra && wm[l]) word[l*9 +: 9] = wd[l*9 +: 9];
        end
        item.due = cyc + LAT[k] - 1;
        item.d   = word;
        if (k == 0) q0.push_back(item); else q1.push_back(item);
      end
      if (w && int'(wa) < DEP[k]) begin
        for (int l = 0; l < 4; l++)
          if (wm[l]) mm[k][wa][l*9 +: 9] = wd[l*9 +: 9];
      end
      if (sc) begin
        clr[k] = DEP[k];
        for (int a = 0; a < 256; a++) mm[k][a] = '0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic        ev, av, ab;
      logic [35:0] ad;
      ev = 1'b0;
      if (k == 0) begin
        if (q0.size() > 0 && q0[0].due == cyc) begin
          ev = 1'b1; last[0] = q0[0].d; void'(q0.pop_front());
        end
        ad = rd0; av = v0; ab = b0;
      end else begin
        if (q1.size() > 0 && q1[0].due == cyc) begin
          ev = 1'b1; last[1] = q1[0].d; void'(q1.pop_front());
        end
        ad = rd1; av = v1; ab = b1;
      end
      checks++;
      if (av !== ev || ad !== last[k] || ab !== (clr[k] > 0)) begin
        failures++;
        $display("FAIL cycle_check dut%0d cyc=%0d valid=%b exp=%b data=%h exp=%h busy=%b exp=%b",
                 k, cyc, av, ev, ad, last[k], ab, (clr[k] > 0));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'd0, 0, 8'd0, 36'd0, 4'd0, 0);
  endtask

  task automatic rand_step(input bit allow_clear);
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
    step(1'($urandom), a, 1'($urandom), b, {4'($urandom), 32'($urandom)}, 4'($urandom),
         allow_clear && ($urandom_range(0, 63) == 0));
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (v0 !== 1'b0 || v1 !== 1'b0 || b0 !== 1'b1 || b1 !== 1'b1 || rd0 !== '0 || rd1 !== '0) begin
      failures++;
      $display("FAIL reset_async valid=%b%b busy=%b%b data=%h/%h exp valid=00 busy=11 data=0",
               v0, v1, b0, b1, rd0, rd1);
    end
  endtask

  task automatic wait_clear_dut0(input string name);
    int n;
    n = 0;
    while (b0 === 1'b1 && n < 400) begin
      rand_step(0);
      n++;
    end
    checks++;
    if (n != 256) begin
      failures++;
      $display("FAIL %s busy_cycles=%0d exp=256", name, n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    enter_reset();
    idle(3);
    rst_n = 1'b1;
    wait_clear_dut0("reset_clear_len");
    step(1, 8'd0, 0, 8'd0, '0, '0, 0);
    step(1, 8'd128, 0, 8'd0, '0, '0, 0);
    step(1, 8'd255, 0, 8'd0, '0, '0, 0);
    checks++;
    if (v0 !== 1'b1 || rd0 !== 36'h0) begin
      failures++;
      $display("FAIL reset_read_zero valid=%b data=%h exp valid=1 data=0", v0, rd0);
    end
    idle(2);
  endtask

  task automatic test_mask();
    logic [35:0] exp_w;
    exp_w = (36'h123456789 & ~36'h00003FE00) | (36'hFFFFFFFFF & 36'h00003FE00);
    step(0, 8'd0, 1, 8'd5, 36'h123456789, 4'b1111, 0);
    step(0, 8'd0, 1, 8'd5, 36'hFFFFFFFFF, 4'b0010, 0);
    step(0, 8'd0, 1, 8'd6, 36'h0FFFFFFFF, 4'b0000, 0);
    step(1, 8'd5, 0, 8'd0, '0, '0, 0);
    checks++;
    if (v1 !== 1'b1 || rd1 !== exp_w) begin
      failures++;
      $display("FAIL mask_lat1 valid=%b data=%h exp=%h", v1, rd1, exp_w);
    end
    step(1, 8'd6, 0, 8'd0, '0, '0, 0);
    checks++;
    if (v0 !== 1'b1 || rd0 !== exp_w) begin
      failures++;
      $display("FAIL mask_lat2 valid=%b data=%h exp=%h", v0, rd0, exp_w);
    end
    idle(2);
  endtask

  task automatic test_collision();
    logic [35:0] exp_c;
    exp_c = (36'h0AAAAAAAA & 36'h00003FFFF) | (36'h155555555 & 36'hFFFFC0000);
    step(0, 8'd0, 1, 8'd7, 36'h0AAAAAAAA, 4'b1111, 0);
    step(1, 8'd7, 1, 8'd7, 36'h155555555, 4'b1100, 0);
    checks++;
    if (v1 !== 1'b1 || rd1 !== exp_c) begin
      failures++;
      $display("FAIL collision_lat1 valid=%b data=%h exp=%h", v1, rd1, exp_c);
    end
    step(0, 8'd0, 1, 8'd7, 36'h000000000, 4'b1111, 0);
    checks++;
    if (v0 !== 1'b1 || rd0 !== exp_c) begin
      failures++;
      $display("FAIL collision_no_late_fwd valid=%b data=%h exp=%h", v0, rd0, exp_c);
    end
    idle(2);
  endtask

  task automatic test_range();
    step(0, 8'd0, 1, 8'd210, 36'h9ABCDEF01, 4'b1111, 0);
    step(1, 8'd210, 0, 8'd0, '0, '0, 0);
    checks++;
    if (v1 !== 1'b1 || rd1 !== 36'h0) begin
      failures++;
      $display("FAIL range_oob_read valid=%b data=%h exp valid=1 data=0", v1, rd1);
    end
    step(0, 8'd0, 1, 8'd199, 36'h876543210, 4'b1111, 0);
    step(1, 8'd199, 0, 8'd0, '0, '0, 0);
    checks++;
    if (v1 !== 1'b1 || rd1 !== 36'h876543210) begin
      failures++;
      $display("FAIL range_last_addr valid=%b data=%h exp=876543210", v1, rd1);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) rand_step(0);
    for (int i = 0; i < 16; i++) step(1, 8'(i * 13), 0, 8'd0, '0, '0, 0);
    idle(2);
  endtask

  task automatic test_clear();
    for (int a = 0; a < 256; a++)
      step(0, 8'd0, 1, 8'(a), {4'($urandom), 32'($urandom)}, 4'b1111, 0);
    step(1, 8'd3, 1, 8'd4, 36'h111111111, 4'b1111, 1);
    checks++;
    if (b0 !== 1'b1 || b1 !== 1'b1) begin
      failures++;
      $display("FAIL clear_busy_rise busy=%b%b exp=11", b0, b1);
    end
    wait_clear_dut0("clear_len");
    for (int a = 0; a < 256; a++) step(1, 8'(a), 0, 8'd0, '0, '0, 0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    step(1, 8'd10, 0, 8'd0, '0, '0, 0);
    enter_reset();
    idle(2);
    rst_n = 1'b1;
    wait_clear_dut0("reset_mid_read_clear_len");
    step(0, 8'd0, 0, 8'd0, '0, '0, 1);
    idle(100);
    enter_reset();
    idle(2);
    rst_n = 1'b1;
    wait_clear_dut0("reset_mid_clear_len");
    for (int i = 0; i < 50; i++) rand_step(1);
    idle(260);
  endtask

  initial begin
    rst_n = 1'b0; ren = 0; raddr = '0; wen = 0; waddr = '0; wdata = '0; wmask = '0; sclr = 0;
    model_reset();
    test_reset();
    test_mask();
    test_collision();
    test_range();
    test_random();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
